// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scancode decoder driving note, octave, amplitude and ADSR controls.
// Define PS2_PARITY_CHECK_EN to reject frames whose data+parity bits are not odd.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       note_in,
    output logic [3:0] note,
    output logic       octave_plus_plus,
    output logic       octave_minus_minus,
    output logic       amp_plus_plus,
    output logic       amp_minus_minus,
    output logic [1:0] ADSR_selector,
    output logic       ADSR_plus_plus,
    output logic       ADSR_minus_minus,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;
    logic          w_dat;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [TW-1:0] r_wdog;
    logic          w_timeout;
    logic          w_accept;
    logic          w_err;
`ifdef PS2_PARITY_CHECK_EN
    logic          r_par, w_par_nxt;
`endif

    logic          r_scan_valid;
    logic [7:0]    r_scan_code;
    logic          r_frame_err;

    logic          r_note_in;
    logic [3:0]    r_note;
    logic          r_ext, r_brk;
    logic          r_oct_p, r_oct_m, r_amp_p, r_amp_m, r_adsr_p, r_adsr_m;
    logic [1:0]    r_sel;
    logic [4:0]    w_map;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_clk_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
            r_clk_filt <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_fall    = r_clk_filt && !r_clk_s2 && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_dat     = r_dat_s2;
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_wdog == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_accept      = 1'b0;
        w_err         = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        w_par_nxt     = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !w_dat) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (w_fall) begin
                    w_shift_nxt = {w_dat, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_fall) begin
`ifdef PS2_PARITY_CHECK_EN
                    w_par_nxt   = w_dat;
`endif
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
`ifdef PS2_PARITY_CHECK_EN
                    if (w_dat && (^{r_shift, r_par})) begin
                        w_accept = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
`else
                    if (w_dat) begin
                        w_accept = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_wdog       <= '0;
            r_scan_valid <= 1'b0;
            r_scan_code  <= '0;
            r_frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_scan_valid <= w_accept;
            r_frame_err  <= w_err;
`ifdef PS2_PARITY_CHECK_EN
            r_par        <= w_par_nxt;
`endif
            if (w_accept) begin
                r_scan_code <= r_shift;
            end
            if (w_state_nxt == ST_IDLE || w_fall) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end

    // {valid, semitone} for the piano-row keys.
    function automatic logic [4:0] f_note_map(input logic [7:0] code);
        logic [4:0] m;
        m = '0;
        case (code)
            8'h1C: m = {1'b1, 4'd0};
            8'h1D: m = {1'b1, 4'd1};
            8'h1B: m = {1'b1, 4'd2};
            8'h24: m = {1'b1, 4'd3};
            8'h23: m = {1'b1, 4'd4};
            8'h2B: m = {1'b1, 4'd5};
            8'h2C: m = {1'b1, 4'd6};
            8'h34: m = {1'b1, 4'd7};
            8'h35: m = {1'b1, 4'd8};
            8'h33: m = {1'b1, 4'd9};
            8'h3C: m = {1'b1, 4'd10};
            8'h3B: m = {1'b1, 4'd11};
            default: m = '0;
        endcase
        return m;
    endfunction

    assign w_map = f_note_map(r_scan_code);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_note_in <= 1'b0;
            r_note    <= '0;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_oct_p   <= 1'b0;
            r_oct_m   <= 1'b0;
            r_amp_p   <= 1'b0;
            r_amp_m   <= 1'b0;
            r_adsr_p  <= 1'b0;
            r_adsr_m  <= 1'b0;
            r_sel     <= '0;
        end else begin
            r_oct_p  <= 1'b0;
            r_oct_m  <= 1'b0;
            r_amp_p  <= 1'b0;
            r_amp_m  <= 1'b0;
            r_adsr_p <= 1'b0;
            r_adsr_m <= 1'b0;
            if (r_scan_valid) begin
                if (r_scan_code == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_scan_code == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    // Extended keys never act; a break only releases the held note.
                    if (!r_ext) begin
                        if (r_brk) begin
                            if (w_map[4] && (w_map[3:0] == r_note)) begin
                                r_note_in <= 1'b0;
                            end
                        end else begin
                            if (w_map[4]) begin
                                r_note    <= w_map[3:0];
                                r_note_in <= 1'b1;
                            end
                            case (r_scan_code)
                                8'h1A: r_oct_m  <= 1'b1;
                                8'h22: r_oct_p  <= 1'b1;
                                8'h21: r_amp_m  <= 1'b1;
                                8'h2A: r_amp_p  <= 1'b1;
                                8'h31: r_adsr_m <= 1'b1;
                                8'h3A: r_adsr_p <= 1'b1;
                                8'h16: r_sel    <= 2'd0;
                                8'h1E: r_sel    <= 2'd1;
                                8'h26: r_sel    <= 2'd2;
                                8'h25: r_sel    <= 2'd3;
                                default: ;
                            endcase
                        end
                    end
                end
            end
        end
    end

    assign note_in            = r_note_in;
    assign note               = r_note;
    assign octave_plus_plus   = r_oct_p;
    assign octave_minus_minus = r_oct_m;
    assign amp_plus_plus      = r_amp_p;
    assign amp_minus_minus    = r_amp_m;
    assign ADSR_selector      = r_sel;
    assign ADSR_plus_plus     = r_adsr_p;
    assign ADSR_minus_minus   = r_adsr_m;
    assign scan_valid         = r_scan_valid;
    assign scan_code          = r_scan_code;
    assign frame_err          = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: PS/2 frame driver, event scoreboard and state vectors.
module tb_ps2_key_decoder;

    localparam int FLEN = 8;
    localparam int TMO  = 400;
    localparam int HALF = 20;

    localparam int EV_NONE = 0;
    localparam int EV_SCAN = 1;
    localparam int EV_FERR = 2;
    localparam int EV_OCTP = 3;
    localparam int EV_OCTM = 4;
    localparam int EV_AMPP = 5;
    localparam int EV_AMPM = 6;
    localparam int EV_ADSP = 7;
    localparam int EV_ADSM = 8;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       note_in;
    logic [3:0] note;
    logic       octave_plus_plus, octave_minus_minus;
    logic       amp_plus_plus, amp_minus_minus;
    logic [1:0] ADSR_selector;
    logic       ADSR_plus_plus, ADSR_minus_minus;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int scan_cyc = -1;
    int rise_cyc = -1;
    logic prev_in = 1'b0;
    int exp_q[$];

    typedef struct {
        logic [7:0] code;
        int         ev;
        logic       exp_in;
        logic [3:0] exp_note;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs[$];

    ps2_key_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .reset              (reset),
        .ps2_clk            (ps2_clk),
        .ps2_dat            (ps2_dat),
        .note_in            (note_in),
        .note               (note),
        .octave_plus_plus   (octave_plus_plus),
        .octave_minus_minus (octave_minus_minus),
        .amp_plus_plus      (amp_plus_plus),
        .amp_minus_minus    (amp_minus_minus),
        .ADSR_selector      (ADSR_selector),
        .ADSR_plus_plus     (ADSR_plus_plus),
        .ADSR_minus_minus   (ADSR_minus_minus),
        .scan_valid         (scan_valid),
        .scan_code          (scan_code),
        .frame_err          (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic got(input int act);
        int e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event_unexpected got=%0h exp=none", act);
        end else begin
            e = exp_q.pop_front();
            if (e != act) begin
                bad++;
                $display("FAIL event got=%0h exp=%0h", act, e);
            end
        end
    endtask

    // Scoreboard side: every observed strobe cycle is one event popped against the queue.
    always @(negedge clk) begin
        int nstr;
        nstr = int'(octave_plus_plus) + int'(octave_minus_minus) + int'(amp_plus_plus)
             + int'(amp_minus_minus) + int'(ADSR_plus_plus) + int'(ADSR_minus_minus);
        if (!reset) begin
            if (scan_valid) begin
                got(EV_SCAN * 256 + int'(scan_code));
                scan_cyc = cyc;
            end
            if (frame_err)          got(EV_FERR * 256);
            if (octave_plus_plus)   got(EV_OCTP * 256);
            if (octave_minus_minus) got(EV_OCTM * 256);
            if (amp_plus_plus)      got(EV_AMPP * 256);
            if (amp_minus_minus)    got(EV_AMPM * 256);
            if (ADSR_plus_plus)     got(EV_ADSP * 256);
            if (ADSR_minus_minus)   got(EV_ADSM * 256);
            if (nstr > 1) chk("strobe_overlap", nstr, 1);
            if (note_in && !prev_in) rise_cyc = cyc;
        end
        prev_in = note_in;
    end

    task automatic send_frame(input logic [7:0] b, input logic bad_stop,
                              input logic bad_par, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_dat = fr[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b, input int ev);
        exp_q.push_back(EV_SCAN * 256 + int'(b));
        if (ev != EV_NONE) exp_q.push_back(ev * 256);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    function automatic vec_t mk(input logic [7:0] c, input int ev, input logic i,
                                input logic [3:0] n, input logic [1:0] s);
        vec_t v;
        v.code = c; v.ev = ev; v.exp_in = i; v.exp_note = n; v.exp_sel = s;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk(8'h23, EV_NONE, 1'b1, 4'd4, 2'd0));
        vecs.push_back(mk(8'hF0, EV_NONE, 1'b1, 4'd4, 2'd0));
        vecs.push_back(mk(8'h1C, EV_NONE, 1'b1, 4'd4, 2'd0));
        vecs.push_back(mk(8'hF0, EV_NONE, 1'b1, 4'd4, 2'd0));
        vecs.push_back(mk(8'h23, EV_NONE, 1'b0, 4'd4, 2'd0));
        vecs.push_back(mk(8'h22, EV_OCTP, 1'b0, 4'd4, 2'd0));
        vecs.push_back(mk(8'h22, EV_OCTP, 1'b0, 4'd4, 2'd0));
        vecs.push_back(mk(8'h22, EV_OCTP, 1'b0, 4'd4, 2'd0));
        vecs.push_back(mk(8'h26, EV_NONE, 1'b0, 4'd4, 2'd2));
        vecs.push_back(mk(8'h3A, EV_ADSP, 1'b0, 4'd4, 2'd2));
        vecs.push_back(mk(8'hE0, EV_NONE, 1'b0, 4'd4, 2'd2));
        vecs.push_back(mk(8'h3A, EV_NONE, 1'b0, 4'd4, 2'd2));
        vecs.push_back(mk(8'h1A, EV_OCTM, 1'b0, 4'd4, 2'd2));
        vecs.push_back(mk(8'h21, EV_AMPM, 1'b0, 4'd4, 2'd2));
        vecs.push_back(mk(8'h2A, EV_AMPP, 1'b0, 4'd4, 2'd2));
        vecs.push_back(mk(8'h31, EV_ADSM, 1'b0, 4'd4, 2'd2));
        vecs.push_back(mk(8'h1E, EV_NONE, 1'b0, 4'd4, 2'd1));
        vecs.push_back(mk(8'h16, EV_NONE, 1'b0, 4'd4, 2'd0));
        vecs.push_back(mk(8'h25, EV_NONE, 1'b0, 4'd4, 2'd3));
        vecs.push_back(mk(8'h3C, EV_NONE, 1'b1, 4'd10, 2'd3));
        vecs.push_back(mk(8'hF0, EV_NONE, 1'b1, 4'd10, 2'd3));
        vecs.push_back(mk(8'h3C, EV_NONE, 1'b0, 4'd10, 2'd3));
        vecs.push_back(mk(8'h55, EV_NONE, 1'b0, 4'd10, 2'd3));
        vecs.push_back(mk(8'hE0, EV_NONE, 1'b0, 4'd10, 2'd3));
        vecs.push_back(mk(8'hF0, EV_NONE, 1'b0, 4'd10, 2'd3));
        vecs.push_back(mk(8'h1C, EV_NONE, 1'b0, 4'd10, 2'd3));
        vecs.push_back(mk(8'h1C, EV_NONE, 1'b1, 4'd0, 2'd3));
        vecs.push_back(mk(8'h3B, EV_NONE, 1'b1, 4'd11, 2'd3));
        vecs.push_back(mk(8'hF0, EV_NONE, 1'b1, 4'd11, 2'd3));
        vecs.push_back(mk(8'h1C, EV_NONE, 1'b1, 4'd11, 2'd3));
        vecs.push_back(mk(8'hF0, EV_NONE, 1'b1, 4'd11, 2'd3));
        vecs.push_back(mk(8'h3B, EV_NONE, 1'b0, 4'd11, 2'd3));

        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_note_in", int'(note_in), 0);
        chk("rst_note", int'(note), 0);
        chk("rst_sel", int'(ADSR_selector), 0);
        chk("rst_strobes", int'({octave_plus_plus, octave_minus_minus, amp_plus_plus,
                                 amp_minus_minus, ADSR_plus_plus, ADSR_minus_minus}), 0);
        chk("rst_scan_valid", int'(scan_valid), 0);
        chk("rst_scan_code", int'(scan_code), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // First note: decode lands exactly one cycle after scan_valid.
        send_good(8'h1C, EV_NONE);
        chk("first_note_in", int'(note_in), 1);
        chk("first_note", int'(note), 0);
        chk("first_latency", rise_cyc, scan_cyc + 1);

        for (int i = 0; i < vecs.size(); i++) begin
            send_good(vecs[i].code, vecs[i].ev);
            chk($sformatf("vec%0d_note_in", i), int'(note_in), int'(vecs[i].exp_in));
            chk($sformatf("vec%0d_note", i), int'(note), int'(vecs[i].exp_note));
            chk($sformatf("vec%0d_sel", i), int'(ADSR_selector), int'(vecs[i].exp_sel));
        end
        chk("q_after_vecs", exp_q.size(), 0);

        exp_q.push_back(EV_FERR * 256);
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        chk("stoperr_note_in", int'(note_in), 0);
        chk("q_after_stoperr", exp_q.size(), 0);

        send_good(8'h1C, EV_NONE);
        chk("pre_rst_note_in", int'(note_in), 1);
        send_frame(8'h23, 1'b0, 1'b0, 4);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_note_in", int'(note_in), 0);
        chk("midrst_note", int'(note), 0);
        send_good(8'h2A, EV_AMPP);
        chk("q_after_midrst", exp_q.size(), 0);

        send_frame(8'h55, 1'b0, 1'b0, 5);
        repeat (TMO + 50) @(negedge clk);
        send_good(8'h2A, EV_AMPP);
        chk("q_after_timeout", exp_q.size(), 0);

`ifdef PS2_PARITY_CHECK_EN
        exp_q.push_back(EV_FERR * 256);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        chk("badpar_note_in", int'(note_in), 0);
`else
        exp_q.push_back(EV_SCAN * 256 + 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        chk("badpar_note_in", int'(note_in), 1);
`endif
        repeat (10) @(negedge clk);
        chk("q_final", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
